bsg_sha256_sched: RTL

Round-robin scheduler that shares one `SHA256_core` among `num_req_p` requesters. Each requester submits a message as a sequence of fixed-width blocks, the last one flagged. The scheduler locks the core to one requester for the whole message and sequences blocks into the core with a chaining/first-block indication. It discards intermediate digests and returns the final digest tagged with the requester id. It sits between the per-client assemblers and the single core inside the SHA wrapper level.

---
 rtl/bsg_sha256_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bsg_sha256_sched.sv
// Round-robin scheduler sharing one SHA-256 core among num_req_p requesters, message-atomic.
// Define BSG_SHA256_SCHED_FIXED_PRIO_EN to select fixed lowest-index priority instead.
module bsg_sha256_sched #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 512,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p-1:0]           req_last_i,
    input  logic [num_req_p*msg_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           core_v_o,
    output logic [msg_width_p-1:0]         core_msg_o,
    output logic                           core_first_o,
    input  logic                           core_ready_i,
    input  logic                           core_v_i,
    input  logic [255:0]                   core_digest_i,
    output logic                           core_yumi_o,
    output logic                           resp_v_o,
    output logic [id_width_lp-1:0]         resp_id_o,
    output logic [255:0]                   resp_data_o,
    input  logic                           resp_yumi_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_e;

    state_e                 state_q, state_d;
    logic [id_width_lp-1:0] grant_q, grant_d;
    logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [255:0]           resp_data_q, resp_data_d;

    logic [id_width_lp-1:0] pick_s;
    logic                   sel_v_s, sel_last_s;
    logic [msg_width_p-1:0] sel_data_s;
    logic [num_req_p-1:0]   grant_oh_s;

    // (base + off) mod num_req_p, with base < num_req_p and off <= num_req_p
    function automatic logic [id_width_lp-1:0] wrap_add(input logic [id_width_lp-1:0] base,
                                                        input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= num_req_p) begin
            sum = sum - num_req_p;
        end else begin
            sum = sum;
        end
        return id_width_lp'(sum);
    endfunction

    // mux out the granted requester's valid/last/data
    always_comb begin
        sel_v_s    = 1'b0;
        sel_last_s = 1'b0;
        sel_data_s = '0;
        grant_oh_s = '0;
        for (int i = 0; i < num_req_p; i++) begin
            grant_oh_s[i] = (grant_q == id_width_lp'(i));
            sel_v_s       = sel_v_s | (grant_oh_s[i] & req_v_i[i]);
            sel_last_s    = sel_last_s | (grant_oh_s[i] & req_last_i[i]);
            sel_data_s    = sel_data_s
                          | ({msg_width_p{grant_oh_s[i]}} & req_data_i[i*msg_width_p +: msg_width_p]);
        end
    end

    // first requesting client scanning upward from rr_ptr_q; descending loop lets the nearest win
    always_comb begin
        pick_s = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (req_v_i[wrap_add(rr_ptr_q, k)]) begin
                pick_s = wrap_add(rr_ptr_q, k);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // next-state and output decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        first_d      = first_q;
        last_d       = last_q;
        resp_data_d  = resp_data_q;
        req_ready_o  = '0;
        core_v_o     = 1'b0;
        core_msg_o   = '0;
        core_first_o = 1'b0;
        core_yumi_o  = 1'b0;
        resp_v_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_v_i) begin
                    grant_d = pick_s;
                    first_d = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                core_v_o     = sel_v_s;
                core_msg_o   = sel_data_s;
                core_first_o = first_q;
                req_ready_o  = core_ready_i ? grant_oh_s : '0;
                if (sel_v_s & core_ready_i) begin
                    last_d  = sel_last_s;
                    first_d = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT: begin
                core_yumi_o = core_v_i;
                if (core_v_i) begin
                    if (last_q) begin
                        resp_data_d = core_digest_i;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i) begin
`ifdef BSG_SHA256_SCHED_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = wrap_add(grant_q, 1);
`endif
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_id_o   = grant_q;
    assign resp_data_o = resp_data_q;

endmodule
